apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

Parametrised APB4 completer with word-addressed backing memory, byte-strobe writes, configurable fixed or pseudo-random wait states, and a read-only region. It answers one bit of a multi-peripheral select bus. It also flags protocol violations from the requester. It sits behind the APB interface as the reference responder model and as a synthesizable peripheral for bring-up.

## Interface
- ADDR_WIDTH, 12: paddr width in bits.
- DATA_WIDTH, 32: data width in bits; must be 8, 16 or 32.
- PERIPHERALS, 4: width of the pselx bus.
- SEL_INDEX, 0: the pselx bit this block answers.
- DEPTH, 64: number of memory words.
- RO_WORDS, 4: words 0..RO_WORDS-1 are read-only.
- WAIT_STATES, 2: wait cycles in fixed mode, or the maximum wait in random mode. Range 0..15.
- WAIT_MODE, 0: 0 selects fixed waits; 1 selects LFSR-random waits.
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- pclk  in  1  APB clock; all logic on the rising edge.
- preset  in  1  synchronous reset, active-high.
- pselx  in  PERIPHERALS  peripheral select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response; valid only while pready=1.
- prot_err  out  1  sticky protocol-violation flag.

## Operation
- sel = pselx[SEL_INDEX].
- Word index = paddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
- States: IDLE, WAIT, DONE (shared package enum).
- IDLE: an edge with sel=1 and penable=0 is a setup.
  - Latch addr, pwrite, pwdata and pstrb.
  - Load cnt with W, where W = WAIT_STATES (mode 0) or lfsr % (WAIT_STATES+1) (mode 1).
  - If W=0, go to DONE; otherwise go to WAIT.
  - The LFSR advances once per setup.
- WAIT: each edge decrements cnt. When cnt reaches 1, go to DONE.
- pready, prdata and pslverr are registered. They assert in the cycle the FSM is in DONE.
- DONE: at the edge where sel=1 and penable=1, the transfer completes.
  - A write commits to memory now, only for bytes with pstrb=1 and only if there is no error.
  - Go to IDLE. pready, pslverr and prdata return to 0.
- Error conditions, pslverr=1 and no memory change:
  - word index >= DEPTH.
  - paddr low bits non-zero (misaligned).
  - write to index < RO_WORDS.
- On error, prdata=0.
- Reads with no error return mem[index]. pstrb is ignored on reads.
- A write with pstrb=0 completes without error and changes nothing.
- prot_err sets on any of the following:
  - penable=1 with sel=1 while in IDLE (no setup phase).
  - paddr, pwrite, pwdata or pstrb changing versus the latched values during WAIT or DONE while sel=1.
  - sel dropping during WAIT or DONE.
- prot_err clears only on reset.
- If sel drops mid-transfer, the FSM aborts to IDLE and no write is committed.

## Timing
- Reset values:
  - prdata=0, pready=0, pslverr=0, prot_err=0.
  - FSM=IDLE, cnt=0, lfsr=LFSR_SEED.
  - All memory words = 0.
- Latency: pready is high in the access cycle numbered W+1 after setup, counting the first access cycle as 1.
- With W=0, a transfer takes 2 cycles: setup, then access with pready=1.
- Back-to-back transfers: the setup that follows the completion edge is accepted normally.
- Reset asserted mid-transfer: all state returns to reset values at that edge and the pending write is discarded.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts left.

## Structure
- Shared package apb_pkg holds:
  - apb_state_e enum.
  - STRB_WIDTH = DATA_WIDTH/8.
  - the LFSR tap constant.
- Sub-module apb_wait_lfsr: 8-bit LFSR with an advance enable and a seed parameter. It is instantiated only when WAIT_MODE=1; otherwise the wait value is a constant.
- Memory is a flat register array of DEPTH words, with per-byte write enables.

## Test plan
- Defaults: write 0xDEADBEEF to 0x010 with pstrb=4'hF, then read 0x010. Each transfer has pready high in its 3rd access cycle; the read returns 0xDEADBEEF with pslverr=0.
- Strobes: write 0x11223344 to 0x020, then write 0xAABBCCDD with pstrb=4'b0101. Read of 0x020 returns 0x11BB33DD.
- Errors: each of the following gives pslverr=1, and a read-back shows the data unchanged:
  - write to 0x004 (read-only region).
  - read of 0x100 (index 64 >= DEPTH); prdata=0.
  - write to 0x011 (misaligned).
- WAIT_STATES=0: back-to-back write then read. Each transfer is exactly 2 cycles and there are no idle cycles between them.
- WAIT_MODE=1: 50 reads. Every wait count is within 0..2 and the sequence matches the reference LFSR model seeded with 0xA5.
- Protocol and reset:
  - penable=1 without setup sets prot_err; it stays 1 until reset.
  - preset asserted during WAIT of a write drops pready and aborts the write; a read-back returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory completer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } apb_state_e;

   // Fibonacci taps for x^8+x^6+x^5+x^4+1, bit i standing for x^(i+1)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic int unsigned strb_width(input int unsigned dw);
      return dw / 8;
   endfunction

   localparam int unsigned STRB_WIDTH = strb_width(32);

endpackage

// File: rtl/apb_slave_mem_wait_lfsr.sv
// 8-bit left-shifting Fibonacci LFSR that steps once per asserted advance.
module apb_wait_lfsr
   import apb_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       advance,
   output logic [7:0] lfsr
);

   always_ff @(posedge pclk) begin
      if (preset) begin
         lfsr <= SEED;
      end else if (advance) begin
         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer with strobed word memory, fixed or LFSR-driven wait states,
// a read-only low region and a sticky requester protocol-violation flag.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned PERIPHERALS = 4,
   parameter int unsigned SEL_INDEX   = 0,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned RO_WORDS    = 4,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned WAIT_MODE   = 0,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic [PERIPHERALS-1:0]  pselx,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr,
   output logic                    prot_err
);

   localparam int unsigned STRB  = strb_width(DATA_WIDTH);
   localparam int unsigned ALIGN = $clog2(STRB);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB - 1);

   apb_state_e              state;
   logic [3:0]              cnt;
   logic [3:0]              wait_val;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB-1:0]         strb_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    sel;
   logic                    setup;
   logic                    changed;
   logic [ADDR_WIDTH-1:0]   resp_addr;
   logic [ADDR_WIDTH-1:0]   resp_idx;
   logic                    resp_write;
   logic                    resp_err;

   assign sel   = pselx[SEL_INDEX];
   assign setup = (state == IDLE) && sel && !penable;

   if (WAIT_MODE == 1) begin : g_rand_wait
      logic [7:0] lfsr;

      apb_wait_lfsr #(
         .SEED(LFSR_SEED)
      ) u_lfsr (
         .pclk   (pclk),
         .preset (preset),
         .advance(setup),
         .lfsr   (lfsr)
      );

      assign wait_val = 4'(lfsr % 8'(WAIT_STATES + 1));
   end else begin : g_fixed_wait
      assign wait_val = 4'(WAIT_STATES);
   end

   // In IDLE the response is decoded straight from the bus so a zero-wait
   // transfer can answer in its first access cycle.
   always_comb begin
      resp_addr  = (state == IDLE) ? paddr  : addr_q;
      resp_write = (state == IDLE) ? pwrite : write_q;
      resp_idx   = resp_addr >> ALIGN;
      resp_err   = (32'(resp_idx) >= 32'(DEPTH))
                || ((resp_addr & ALIGN_MASK) != '0)
                || (resp_write && (32'(resp_idx) < 32'(RO_WORDS)));
      changed    = (paddr != addr_q) || (pwrite != write_q)
                || (pwdata != wdata_q) || (pstrb != strb_q);
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         prdata   <= '0;
         pready   <= 1'b0;
         pslverr  <= 1'b0;
         prot_err <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (((state == IDLE) && sel && penable) ||
             ((state != IDLE) && (!sel || changed))) begin
            prot_err <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (setup) begin
                  addr_q  <= paddr;
                  write_q <= pwrite;
                  wdata_q <= pwdata;
                  strb_q  <= pstrb;
                  cnt     <= wait_val;
                  if (wait_val == '0) begin
                     state   <= DONE;
                     pready  <= 1'b1;
                     pslverr <= resp_err;
                     prdata  <= (resp_err || resp_write) ? '0 : mem[resp_idx[IDX_W-1:0]];
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!sel) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     state   <= DONE;
                     pready  <= 1'b1;
                     pslverr <= resp_err;
                     prdata  <= (resp_err || resp_write) ? '0 : mem[resp_idx[IDX_W-1:0]];
                  end
               end
            end
            DONE: begin
               if (!sel || penable) begin
                  if (sel && write_q && !pslverr) begin
                     for (int unsigned b = 0; b < STRB; b++) begin
                        if (strb_q[b]) begin
                           mem[resp_idx[IDX_W-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                     end
                  end
                  state   <= IDLE;
                  cnt     <= '0;
                  pready  <= 1'b0;
                  pslverr <= 1'b0;
                  prdata  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench: three completers share one APB bus on select bits 0..2
// (default, zero-wait, random-wait) and are checked against a word-array model.
module tb_apb_slave_mem;
   import apb_pkg::*;

   logic                  pclk = 1'b0;
   logic                  preset = 1'b1;
   logic [3:0]            pselx = '0;
   logic                  penable = 1'b0;
   logic                  pwrite = 1'b0;
   logic [11:0]           paddr = '0;
   logic [31:0]           pwdata = '0;
   logic [STRB_WIDTH-1:0] pstrb = '0;

   logic [2:0][31:0]      rdata;
   logic [2:0]            rdy, serr, perr;

   always #5 pclk = ~pclk;

   apb_slave_mem #(.SEL_INDEX(0)) u0 (
      .pclk(pclk), .preset(preset), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(rdata[0]), .pready(rdy[0]),
      .pslverr(serr[0]), .prot_err(perr[0]));

   apb_slave_mem #(.SEL_INDEX(1), .WAIT_STATES(0)) u1 (
      .pclk(pclk), .preset(preset), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(rdata[1]), .pready(rdy[1]),
      .pslverr(serr[1]), .prot_err(perr[1]));

   apb_slave_mem #(.SEL_INDEX(2), .WAIT_MODE(1), .LFSR_SEED(8'hA5)) u2 (
      .pclk(pclk), .preset(preset), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(rdata[2]), .pready(rdy[2]),
      .pslverr(serr[2]), .prot_err(perr[2]));

   typedef struct {
      int          inst;
      bit          chk_data;
      logic [31:0] data;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   logic [31:0] mdl [3][64];
   logic [7:0]  lfsr_m;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 64; i++) mdl[k][i] = '0;
      lfsr_m = 8'hA5;
   endtask

   // Drives one transfer starting just after a rising edge; returns just after
   // its completion edge so a following call is back-to-back.
   task automatic xfer(input int inst, input logic wr, input logic [11:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
      exp_t e;
      int   idx;
      int   w;
      bit   got;
      idx = int'(addr >> 2);
      e.inst = inst;
      e.chk_data = !wr;
      e.err = (idx >= 64) || (addr % 4 != 0) || (wr && idx < 4);
      e.data = (!wr && !e.err) ? mdl[inst][idx] : 32'h0;
      if (wr && !e.err)
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[inst][idx][b*8 +: 8] = data[b*8 +: 8];
      if (inst == 2) begin
         w = int'(lfsr_m) % 3;
         lfsr_m = lfsr_step(lfsr_m);
      end else begin
         w = (inst == 0) ? 2 : 0;
      end
      e.acc = w + 1;
      sbq.push_back(e);

      pselx = 4'(1 << inst);
      penable = 1'b0;
      pwrite = wr;
      paddr = addr;
      pwdata = data;
      pstrb = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge pclk);
         if (rdy[inst]) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checks++;
         $display("FAIL pready_timeout: inst %0d addr %h got no pready expected pready within 40 cycles", inst, addr);
         if (sbq.size() != 0) void'(sbq.pop_back());
      end
      @(posedge pclk); #1;
      pselx = '0;
      penable = 1'b0;
   endtask

   // Monitor: counts access cycles since setup and scores each pready.
   int  acc_cnt = 0;
   bit  active = 0;
   always @(negedge pclk) begin
      int   cur;
      exp_t e;
      cur = pselx[0] ? 0 : (pselx[1] ? 1 : 2);
      if (preset) begin
         active = 0;
      end else if (pselx != '0 && !penable) begin
         active = 1;
         acc_cnt = 0;
      end else if (pselx != '0 && penable && active) begin
         acc_cnt++;
         if (rdy[cur]) begin
            active = 0;
            if (sbq.size() == 0) begin
               check("unexpected_pready", 32'(cur), 32'hFFFF_FFFF);
            end else begin
               e = sbq.pop_front();
               check("resp_inst", 32'(cur), 32'(e.inst));
               check("resp_wait", 32'(acc_cnt), 32'(e.acc));
               check("resp_pslverr", 32'(serr[cur]), 32'(e.err));
               if (e.chk_data) check("resp_prdata", rdata[cur], e.data);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1);
   end

   initial begin
      int          t0;
      logic [11:0] a;
      clear_model();
      repeat (3) @(posedge pclk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_pready", 32'(rdy[k]), 32'h0);
         check("rst_pslverr", 32'(serr[k]), 32'h0);
         check("rst_prdata", rdata[k], 32'h0);
         check("rst_prot_err", 32'(perr[k]), 32'h0);
      end
      preset = 1'b0;
      @(posedge pclk); #1;

      xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'h0);
      xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF);
      xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101);
      xfer(0, 1'b0, 12'h020, 32'h0, 4'h0);
      xfer(0, 1'b1, 12'h024, 32'h55667788, 4'h0);
      xfer(0, 1'b0, 12'h024, 32'h0, 4'h0);

      xfer(0, 1'b1, 12'h004, 32'hCAFEF00D, 4'hF);
      xfer(0, 1'b0, 12'h004, 32'h0, 4'h0);
      xfer(0, 1'b0, 12'h100, 32'h0, 4'h0);
      xfer(0, 1'b1, 12'h011, 32'h12345678, 4'hF);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'h0);

      t0 = cyc;
      xfer(1, 1'b1, 12'h040, 32'h0BADF00D, 4'hF);
      xfer(1, 1'b0, 12'h040, 32'h0, 4'h0);
      check("b2b_cycles", 32'(cyc - t0), 32'd4);

      for (int i = 0; i < 50; i++)
         xfer(2, 1'b0, 12'($urandom_range(0, 63) * 4), 32'h0, 4'h0);

      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 12'h13F))
                                         : 12'($urandom_range(0, 63) * 4);
         xfer($urandom_range(0, 2), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge pclk); #1;
         end
      end

      pselx = 4'b0001;
      penable = 1'b1;
      @(posedge pclk); #1;
      pselx = '0;
      penable = 1'b0;
      check("prot_err_set", 32'(perr[0]), 32'h1);
      check("prot_err_other", 32'(perr[1]), 32'h0);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'h0);
      repeat (3) @(posedge pclk);
      #1;
      check("prot_err_sticky", 32'(perr[0]), 32'h1);

      pselx = 4'b0001;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 12'h030;
      pwdata = 32'h13579BDF;
      pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b1;
      pselx = '0;
      penable = 1'b0;
      @(posedge pclk); #1;
      check("abort_pready", 32'(rdy[0]), 32'h0);
      check("abort_prot_err", 32'(perr[0]), 32'h0);
      @(posedge pclk); #1;
      preset = 1'b0;
      clear_model();
      @(posedge pclk); #1;
      xfer(0, 1'b0, 12'h030, 32'h0, 4'h0);
      xfer(0, 1'b0, 12'h010, 32'h0, 4'h0);
      xfer(2, 1'b0, 12'h000, 32'h0, 4'h0);

      repeat (5) @(posedge pclk);
      check("scoreboard_drained", 32'(sbq.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
